mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage CPU: receiver of the EX→MEM bus and consumer of the data-SRAM read port that EX drives. Accepts one instruction per cycle under the valid/allowin handshake. Captures the synchronous-SRAM read data on the instruction's first MEM cycle and holds it across WB back-pressure. Performs load byte/halfword selection with sign/zero extension, and forwards the final result to WB and to ID for bypassing.

## Interface
- No parameters.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_to_mem_valid  in  1  EX holds a valid instruction.
- ex_to_mem_bus  in  108  {pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], rkd_value[31:0], addr_lo[1:0], op_b, op_h, op_u}, MSB first.
- mem_allowin  out  1  MEM accepts an instruction this cycle.
- data_sram_rdata  in  32  synchronous SRAM read data, valid the cycle after EX's request.
- wb_allowin  in  1  WB accepts this cycle.
- mem_to_wb_valid  out  1  MEM presents a valid instruction.
- mem_to_wb_bus  out  70  {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}.
- mem_to_id_bus  out  38  {rf_we & mem_valid, rf_waddr[4:0], final_result[31:0]}, bypass path.

## Operation
- State: mem_valid, the latched 108-bit bus, rdata_buf[31:0], rdata_held.
- mem_ready_go = 1. mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin). mem_to_wb_valid = mem_valid.
- mem_valid: on a clock edge with mem_allowin = 1 it loads ex_to_mem_valid; otherwise it holds.
- Bus latch: loads when ex_to_mem_valid & mem_allowin; otherwise it holds.
- Read-data hold:
  - On accept, clear rdata_held.
  - On any cycle with mem_valid & ~rdata_held & ~(wb_allowin), load rdata_buf ← data_sram_rdata and set rdata_held.
  - load_word = rdata_held ? rdata_buf : data_sram_rdata.
- Load extraction:
  - op_b: byte = load_word[8*addr_lo +: 8]. Zero-extend if op_u, else sign-extend bit 7.
  - op_h: half = addr_lo[1] ? load_word[31:16] : load_word[15:0]. Zero-extend if op_u, else sign-extend bit 15.
  - Neither op_b nor op_h: the full 32-bit word.
  - addr_lo[0] is ignored for halfwords; misalignment is not checked here.
- final_result = res_from_mem ? extracted_load : alu_result. rkd_value is latched but unused.
- rf_we on mem_to_wb_bus is passed as latched. The EX side already gates it with its valid. WB additionally qualifies it with mem_to_wb_valid.
- Stores (rf_we = 0, res_from_mem = 0) pass through unchanged with final_result = alu_result.

## Timing
- Reset values:
  - mem_valid = 0, so mem_allowin = 1 and mem_to_wb_valid = 0.
  - Latched bus = 0, rdata_buf = 0, rdata_held = 0.
  - Therefore mem_to_wb_bus = 0 and mem_to_id_bus = 0.
- Reset has priority over accept in the same cycle. Reset asserted while a load is stalled drops the instruction and the held data.
- Latency: one cycle EX→MEM. An instruction accepted at edge N is visible on mem_to_wb_bus during cycle N and leaves at the first edge with wb_allowin = 1.
- SRAM read: data_sram_rdata is sampled combinationally in the first MEM cycle. It is captured only if that cycle stalls. Later changes to data_sram_rdata, caused by EX issuing the next request, must not affect final_result.
- Simultaneous leave and accept (mem_valid & wb_allowin & ex_to_mem_valid): the new instruction is latched and rdata_held is cleared at the same edge. There are no bubbles.
- Bubble: ex_to_mem_valid = 0 with mem_allowin = 1 clears mem_valid. The bus latch holds its stale value, but it is masked by mem_to_id_bus gating and by mem_to_wb_valid.
- Fully combinational from the latched state and data_sram_rdata to all outputs, except mem_allowin, which depends combinationally on wb_allowin.

## Test plan
- ld.b, addr_lo = 3, op_u = 0, rdata = 0x80FF_1234, wb_allowin = 1 → final_result 0xFFFF_FF80; mem_to_wb_valid high for exactly 1 cycle.
- ld.hu, addr_lo = 2, rdata = 0x80FF_1234 → 0x0000_80FF. ld.h with the same inputs → 0xFFFF_80FF. ld.bu, addr_lo = 1 → 0x0000_0012.
- ld.w with rdata = 0x1122_3344 in the first MEM cycle; wb_allowin low for 3 cycles; rdata changes to 0xDEAD_BEEF in cycle 2 → final_result stays 0x1122_3344 throughout; mem_allowin = 0 during the stall; the instruction leaves on the first wb_allowin = 1 edge.
- Back-to-back: add (alu_result 0x5), ld.w (rdata 0xA), st.w → the three instructions appear on consecutive cycles with results 0x5, 0xA, and the store's alu_result. mem_to_id_bus rf_we = 1, 1, 0.
- Reset asserted during a stalled load → the next cycle shows mem_valid = 0, all outputs 0, and mem_allowin = 1. A following load uses live rdata, not the old buffer.
- Bubble after a valid instruction, with wb_allowin = 1 → mem_to_wb_valid = 0 and mem_to_id_bus rf_we bit = 0 despite the stale latched rf_we = 1.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX->MEM->WB/ID handshake and bus bundle for the memory-access stage.
// The master modport is the surrounding pipeline; the slave modport is mem_stage.
interface mem_stage_if;
  logic         ex_to_mem_valid;
  logic [107:0] ex_to_mem_bus;
  logic         mem_allowin;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_bus;
  logic [37:0]  mem_to_id_bus;

  modport master (
    output ex_to_mem_valid, ex_to_mem_bus, data_sram_rdata, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );

  modport slave (
    input  ex_to_mem_valid, ex_to_mem_bus, data_sram_rdata, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX bus, captures SRAM read data
// across WB stalls, extracts/extends loads and forwards results to WB and ID.
module mem_stage (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave io
);

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic [1:0]  addr_lo;
    logic        op_b;
    logic        op_h;
    logic        op_u;
  } ex_bus_t;

  ex_bus_t     bus_r;
  logic        mem_valid;
  logic [31:0] rdata_buf;
  logic        rdata_held;

  logic        mem_ready_go;
  logic        accept;
  logic [31:0] load_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] extracted;
  logic [31:0] final_result;
  logic        unused_rkd;

  assign mem_ready_go       = 1'b1;
  assign io.mem_allowin     = ~mem_valid | (mem_ready_go & io.wb_allowin);
  assign io.mem_to_wb_valid = mem_valid;
  assign accept             = io.ex_to_mem_valid & io.mem_allowin;

  // rkd_value rides along for store data in earlier stages; nothing here reads it.
  assign unused_rkd = ^bus_r.rkd_value;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the read buffer is small control state, so it is reset too.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      bus_r      <= '0;
      rdata_buf  <= '0;
      rdata_held <= 1'b0;
    end else begin
      if (io.mem_allowin) mem_valid <= io.ex_to_mem_valid;
      if (accept) bus_r <= io.ex_to_mem_bus;

      // SRAM data is only valid in the first MEM cycle; freeze it if we stall.
      if (accept) begin
        rdata_held <= 1'b0;
      end else if (mem_valid & ~rdata_held & ~io.wb_allowin) begin
        rdata_buf  <= io.data_sram_rdata;
        rdata_held <= 1'b1;
      end
    end
  end

  assign load_word = rdata_held ? rdata_buf : io.data_sram_rdata;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    ld_byte   = load_word[{bus_r.addr_lo, 3'b000} +: 8];
    ld_half   = bus_r.addr_lo[1] ? load_word[31:16] : load_word[15:0];
    extracted = load_word;
    if (bus_r.op_b) begin
      extracted = {{24{~bus_r.op_u & ld_byte[7]}}, ld_byte};
    end else if (bus_r.op_h) begin
      extracted = {{16{~bus_r.op_u & ld_half[15]}}, ld_half};
    end
  end

  assign final_result = bus_r.res_from_mem ? extracted : bus_r.alu_result;

  assign io.mem_to_wb_bus = {bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, final_result};
  assign io.mem_to_id_bus = {bus_r.rf_we & mem_valid, bus_r.rf_waddr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by a
// random phase, all compared against a behavioural pipeline model.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic [1:0]  addr_lo;
    logic        op_b;
    logic        op_h;
    logic        op_u;
  } ex_bus_t;

  logic clk = 1'b0;
  logic reset;
  mem_stage_if io ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Values driven this cycle, remembered for the model update at the edge.
  logic        drv_v;
  ex_bus_t     drv_bus;
  logic [31:0] drv_rd;
  logic        drv_wa;
  logic        drv_rst;

  // Model: instruction currently in MEM and the word seen in its first MEM cycle.
  logic        m_valid = 1'b0;
  ex_bus_t     m_bus   = '0;
  logic        m_first = 1'b0;
  logic [31:0] m_word  = '0;
  logic        m_zero  = 1'b0;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ex_bus_t mk(input logic [31:0] pc, input logic rfm, input logic we,
                                 input logic [4:0] wa, input logic [31:0] alu,
                                 input logic [1:0] alo, input logic b, input logic h,
                                 input logic u);
    ex_bus_t r;
    r.pc = pc; r.res_from_mem = rfm; r.rf_we = we; r.rf_waddr = wa;
    r.alu_result = alu; r.rkd_value = $urandom; r.addr_lo = alo;
    r.op_b = b; r.op_h = h; r.op_u = u;
    return r;
  endfunction

  // Load semantics from arithmetic: shift, mask, then wrap negative values.
  function automatic logic [31:0] ref_result(input ex_bus_t i, input logic [31:0] w);
    logic [31:0] v;
    if (!i.res_from_mem) return i.alu_result;
    if (i.op_b) begin
      v = (w >> (8 * i.addr_lo)) & 32'hFF;
      if (!i.op_u && v >= 128) v = v - 256;
      return v;
    end
    if (i.op_h) begin
      v = (w >> (i.addr_lo[1] ? 16 : 0)) & 32'hFFFF;
      if (!i.op_u && v >= 32768) v = v - 65536;
      return v;
    end
    return w;
  endfunction

  task automatic check_model();
    logic [31:0] res;
    chk("allowin", 70'(io.mem_allowin), 70'(!m_valid || drv_wa));
    chk("wb_valid", 70'(io.mem_to_wb_valid), 70'(m_valid));
    chk("id_we", 70'(io.mem_to_id_bus[37]), 70'(m_valid && m_bus.rf_we));
    if (m_valid) begin
      res = ref_result(m_bus, m_first ? drv_rd : m_word);
      chk("wb_bus", io.mem_to_wb_bus, {m_bus.pc, m_bus.rf_we, m_bus.rf_waddr, res});
      chk("id_bus", 70'(io.mem_to_id_bus), 70'({m_bus.rf_we, m_bus.rf_waddr, res}));
    end else if (m_zero) begin
      chk("wb_bus_zero", io.mem_to_wb_bus, 70'd0);
      chk("id_bus_zero", 70'(io.mem_to_id_bus), 70'd0);
    end
  endtask

  task automatic drive(input logic v, input ex_bus_t b, input logic [31:0] rd,
                       input logic wa, input logic rst);
    drv_v = v; drv_bus = b; drv_rd = rd; drv_wa = wa; drv_rst = rst;
    io.ex_to_mem_valid = v;
    io.ex_to_mem_bus   = b;
    io.data_sram_rdata = rd;
    io.wb_allowin      = wa;
    reset              = rst;
    #4;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (drv_rst) begin
      m_valid = 1'b0; m_bus = '0; m_first = 1'b0; m_word = '0; m_zero = 1'b1;
    end else if (!m_valid || drv_wa) begin
      m_valid = drv_v;
      if (drv_v) begin
        m_bus = drv_bus; m_first = 1'b1; m_zero = 1'b0;
      end
    end else if (m_first) begin
      m_word  = drv_rd;
      m_first = 1'b0;
    end
    #1;
  endtask

  ex_bus_t nop_b, ldb, ldhu, ldh, ldbu, ldw, add_i, st_i, rb;
  logic [31:0] word_v;

  initial begin
    nop_b = '0;
    drive(1'b0, nop_b, 32'h0, 1'b1, 1'b1); tick();
    drive(1'b1, mk(32'h100, 1, 1, 5'd1, 32'h1, 2'd0, 0, 0, 0), 32'h0, 1'b1, 1'b1); tick();
    // Reset state: everything zero, allowin high.
    drive(1'b0, nop_b, 32'hCAFE_F00D, 1'b1, 1'b0);
    chk("rst_allowin", 70'(io.mem_allowin), 70'd1);
    tick();

    // ld.b addr_lo=3 signed, then valid exactly one cycle.
    ldb = mk(32'h1000, 1, 1, 5'd4, 32'h0, 2'd3, 1, 0, 0);
    drive(1'b1, ldb, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, nop_b, 32'h80FF_1234, 1'b1, 1'b0);
    chk("ldb_const", 70'(io.mem_to_wb_bus[31:0]), 70'(32'hFFFF_FF80));
    tick();
    drive(1'b0, nop_b, 32'h0, 1'b1, 1'b0);
    chk("ldb_one_cycle", 70'(io.mem_to_wb_valid), 70'd0);
    tick();

    // ld.hu, ld.h, ld.bu back to back.
    ldhu = mk(32'h1004, 1, 1, 5'd5, 32'h0, 2'd2, 0, 1, 1);
    ldh  = mk(32'h1008, 1, 1, 5'd6, 32'h0, 2'd2, 0, 1, 0);
    ldbu = mk(32'h100C, 1, 1, 5'd7, 32'h0, 2'd1, 1, 0, 1);
    drive(1'b1, ldhu, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, ldh, 32'h80FF_1234, 1'b1, 1'b0);
    chk("ldhu_const", 70'(io.mem_to_wb_bus[31:0]), 70'(32'h0000_80FF));
    tick();
    drive(1'b1, ldbu, 32'h80FF_1234, 1'b1, 1'b0);
    chk("ldh_const", 70'(io.mem_to_wb_bus[31:0]), 70'(32'hFFFF_80FF));
    tick();
    drive(1'b0, nop_b, 32'h80FF_1234, 1'b1, 1'b0);
    chk("ldbu_const", 70'(io.mem_to_wb_bus[31:0]), 70'(32'h0000_0012));
    tick();

    // ld.w stalled three cycles while SRAM data changes underneath.
    ldw   = mk(32'h2000, 1, 1, 5'd8, 32'h0, 2'd0, 0, 0, 0);
    add_i = mk(32'h2004, 0, 1, 5'd9, 32'h5, 2'd0, 0, 0, 0);
    drive(1'b1, ldw, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, add_i, 32'h1122_3344, 1'b0, 1'b0);
    chk("stall_allowin", 70'(io.mem_allowin), 70'd0);
    tick();
    drive(1'b1, add_i, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("stall_hold", 70'(io.mem_to_wb_bus[31:0]), 70'(32'h1122_3344));
    tick();
    drive(1'b1, add_i, 32'hDEAD_BEEF, 1'b0, 1'b0); tick();
    drive(1'b1, add_i, 32'h0BAD_0BAD, 1'b1, 1'b0);
    chk("stall_leave", 70'(io.mem_to_wb_bus[31:0]), 70'(32'h1122_3344));
    tick();

    // add, ld.w, st.w back to back (add entered at the previous edge).
    ldw  = mk(32'h2008, 1, 1, 5'd10, 32'h0, 2'd0, 0, 0, 0);
    st_i = mk(32'h200C, 0, 0, 5'd0, 32'h0000_8000, 2'd0, 0, 0, 0);
    drive(1'b1, ldw, 32'h0, 1'b1, 1'b0);
    chk("b2b_add", 70'(io.mem_to_id_bus), 70'({1'b1, 5'd9, 32'h5}));
    tick();
    drive(1'b1, st_i, 32'hA, 1'b1, 1'b0);
    chk("b2b_ld", 70'(io.mem_to_id_bus), 70'({1'b1, 5'd10, 32'hA}));
    tick();
    drive(1'b0, nop_b, 32'h0, 1'b1, 1'b0);
    chk("b2b_st", 70'(io.mem_to_id_bus), 70'({1'b0, 5'd0, 32'h0000_8000}));
    tick();

    // Reset during a stalled load, then a load must use live data.
    drive(1'b1, ldw, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, nop_b, 32'h55, 1'b0, 1'b0); tick();
    drive(1'b0, nop_b, 32'h66, 1'b0, 1'b1); tick();
    drive(1'b0, nop_b, 32'h0, 1'b0, 1'b0);
    chk("rst_stall_allowin", 70'(io.mem_allowin), 70'd1);
    chk("rst_stall_wb", io.mem_to_wb_bus, 70'd0);
    tick();
    drive(1'b1, ldw, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, nop_b, 32'h77, 1'b1, 1'b0);
    chk("live_rdata", 70'(io.mem_to_wb_bus[31:0]), 70'(32'h77));
    tick();

    // Bubble after a writing instruction.
    drive(1'b1, add_i, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, nop_b, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, nop_b, 32'h0, 1'b1, 1'b0);
    chk("bubble_valid", 70'(io.mem_to_wb_valid), 70'd0);
    chk("bubble_id_we", 70'(io.mem_to_id_bus[37]), 70'd0);
    tick();

    // Random phase against the model.
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 4);
      rb = mk($urandom, kind != 0, $urandom_range(0, 1), 5'($urandom), $urandom,
              2'($urandom), kind == 1, kind == 2, $urandom_range(0, 1));
      word_v = $urandom;
      drive($urandom_range(0, 3) != 0, rb, word_v, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
